// File: rtl/muxn_pipe.sv
// muxn_pipe: N-way registered selector with valid/ready handshake; define MUXN_SKID_EN for the 2-entry skid variant.
module muxn_pipe #(
  parameter int WIDTH = 32,
  parameter int N = 4,
  parameter int SW = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0]    out_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sel_err
);
  localparam logic [SW:0] NL = (SW+1)'(N);
  logic [WIDTH-1:0] sel_data;
  logic oor, accept, xfer;
  assign oor = {1'b0, in_sel} >= NL;
  assign accept = in_valid && in_ready;
  assign xfer = out_valid && out_ready;
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++)
      if (in_sel == SW'(k)) sel_data = in_data[k*WIDTH +: WIDTH];
  end
`ifdef MUXN_SKID_EN
  logic [WIDTH-1:0] skid_data;
  logic [SW-1:0] skid_sel;
  logic skid_valid, to_main;
  assign in_ready = !skid_valid && !flush;
  assign to_main = accept && (!out_valid || (xfer && !skid_valid));
`else
  assign in_ready = (!out_valid || out_ready) && !flush;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      sel_err <= 1'b0;
`ifdef MUXN_SKID_EN
      skid_valid <= 1'b0;
      skid_data <= '0;
      skid_sel <= '0;
`endif
    end else begin
      if (accept && oor) sel_err <= 1'b1;
`ifdef MUXN_SKID_EN
      if (flush) begin
        out_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else begin
        if (xfer && skid_valid) begin
          out_data <= skid_data;
          out_sel <= skid_sel;
          out_valid <= 1'b1;
        end else if (to_main) begin
          out_data <= sel_data;
          out_sel <= in_sel;
          out_valid <= 1'b1;
        end else if (xfer) out_valid <= 1'b0;
        if (accept && !to_main) begin
          skid_data <= sel_data;
          skid_sel <= in_sel;
          skid_valid <= 1'b1;
        end else if (xfer) skid_valid <= 1'b0;
      end
`else
      if (flush) out_valid <= 1'b0;
      else if (accept) begin
        out_data <= sel_data;
        out_sel <= in_sel;
        out_valid <= 1'b1;
      end else if (xfer) out_valid <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_muxn_pipe.sv
// tb_muxn_pipe: directed checks of muxn_pipe with N=3, WIDTH=8 (skid scenarios under MUXN_SKID_EN).
module tb_muxn_pipe;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [23:0] in_data = {8'h33, 8'h22, 8'h11};
  logic [1:0] in_sel = 0, out_sel;
  logic [7:0] out_data;
  logic in_ready, out_valid, sel_err;
  int total = 0, bad = 0;
  muxn_pipe #(.WIDTH(8), .N(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick; tick;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_data", out_data, 0);
    chk("rst_sel", out_sel, 0);
    chk("rst_err", sel_err, 0);
    rst = 0;
    // streaming
    out_ready = 1; in_valid = 1;
    in_sel = 0; tick;
    chk("s0_data", out_data, 8'h11); chk("s0_rdy", in_ready, 1);
    in_sel = 1; tick;
    chk("s1_data", out_data, 8'h22); chk("s1_rdy", in_ready, 1);
    in_sel = 2; tick;
    chk("s2_data", out_data, 8'h33); chk("s2_rdy", in_ready, 1);
    in_sel = 1; tick;
    chk("s3_data", out_data, 8'h22); chk("s3_valid", out_valid, 1);
    in_valid = 0; tick;
    chk("s_drain", out_valid, 0);
`ifdef MUXN_SKID_EN
    out_ready = 0; in_valid = 1; in_sel = 2; #1;
    chk("bp_rdy0", in_ready, 1);
    tick;
    chk("bp_d0", out_data, 8'h33); chk("bp_rdy1", in_ready, 1);
    in_sel = 0; tick;
    chk("bp_hold", out_data, 8'h33); chk("bp_rdy2", in_ready, 0);
    in_valid = 0; tick;
    chk("bp_rdy3", in_ready, 0);
    out_ready = 1; #1;
    chk("bp_reg_rdy", in_ready, 0);
    tick;
    chk("bp_d1", out_data, 8'h11); chk("bp_v1", out_valid, 1); chk("bp_rdy4", in_ready, 1);
    tick;
    chk("bp_empty", out_valid, 0);
`else
    out_ready = 0; in_valid = 1; in_sel = 0; tick;
    chk("ns_held", out_data, 8'h11); chk("ns_rdy0", in_ready, 0);
    in_sel = 2; tick;
    chk("ns_keep", out_data, 8'h11);
    out_ready = 1; #1;
    chk("ns_rdy1", in_ready, 1);
    tick;
    chk("ns_d2", out_data, 8'h33); chk("ns_v2", out_valid, 1);
    in_valid = 0; tick;
    chk("ns_empty", out_valid, 0);
`endif
    // out-of-range select
    out_ready = 1; in_valid = 1; in_sel = 3; tick;
    chk("oor_data", out_data, 0); chk("oor_sel", out_sel, 3);
    chk("oor_err", sel_err, 1); chk("oor_valid", out_valid, 1);
    in_sel = 1; tick;
    chk("oor_next", out_data, 8'h22); chk("oor_sticky", sel_err, 1);
    in_valid = 0; tick;
    chk("oor_drain", out_valid, 0);
    // flush with held beat(s) and a beat on offer
    out_ready = 0; in_valid = 1; in_sel = 0; tick;
    in_sel = 2; tick;
    chk("fl_pre", out_valid, 1);
    in_sel = 1; flush = 1; #1;
    chk("fl_rdy", in_ready, 0);
    tick;
    chk("fl_valid", out_valid, 0);
    flush = 0; in_valid = 0; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("fl_none", out_valid, 0);
    end
    chk("fl_err", sel_err, 1);
    // reset mid-stream
    out_ready = 0; in_valid = 1; in_sel = 0; tick;
    in_sel = 2; tick;
    rst = 1; tick;
    chk("mr_valid", out_valid, 0); chk("mr_rdy", in_ready, 1);
    chk("mr_data", out_data, 0); chk("mr_err", sel_err, 0);
    rst = 0; out_ready = 1; in_sel = 2; tick;
    chk("mr_after", out_data, 8'h33); chk("mr_av", out_valid, 1);
    in_valid = 0; tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muxn_pipe.md
# muxn_pipe

Parametrised N-way registered selector with a valid/ready handshake and an optional skid buffer. It generalises the combinational 2/3-input pipeline selectors to any input count and width. It adds output registration, back-pressure and out-of-range select detection. It sits between pipeline stages wherever a selected operand must cross a stage boundary under stall control, for example forwarded operands feeding the execute stage.

## Interface
Parameters:
- `WIDTH`, 32: data width of each input and of the output.
- `N`, 4: number of data inputs, 2..16.
- `SW`, `$clog2(N)` (minimum 1): select width, derived; never overridden.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `flush`, input, 1: synchronous clear of all buffered beats.
- `in_data`, input, N*WIDTH: packed inputs; input k occupies bits `[k*WIDTH +: WIDTH]`.
- `in_sel`, input, SW: index of the input to pass.
- `in_valid`, input, 1: upstream beat present.
- `in_ready`, output, 1: block accepts a beat this cycle.
- `out_data`, output, WIDTH: selected data of the head beat.
- `out_sel`, output, SW: `in_sel` captured with the head beat.
- `out_valid`, output, 1: head beat present.
- `out_ready`, input, 1: downstream accepts the head beat.
- `sel_err`, output, 1: sticky flag, set when an out-of-range select is accepted.

## Operation
- Accept occurs when `in_valid && in_ready`. Transfer occurs when `out_valid && out_ready`.
- On accept, the block captures `in_data[in_sel]` and `in_sel`.
  - If `in_sel >= N`, the captured data is all zeros, the beat is still passed, and `sel_err` is set.
  - `sel_err` clears only on `rst`.
- Storage is a main register (head) plus a skid register, each with its own valid bit. Beats leave in acceptance order.
- Storage rules:
  - On accept, the beat goes to main if main is empty, or if main is transferring this cycle and skid is empty.
  - Otherwise the beat goes to skid.
  - On transfer, if skid holds a beat, skid moves to main.
- `in_ready = !skid_valid`. It is a register output with no combinational path from `out_ready`.
- `flush`:
  - Clears both valid bits on the next edge.
  - Forces `in_ready` low in the same cycle, so a beat presented with `flush` is not accepted.
  - Does not clear `sel_err`.
  - A transfer in the same cycle still counts as completed downstream.
- Data and select registers hold their values when not loaded. Their contents are don't-care while the matching valid bit is low.

## Timing
- Latency is 1 cycle: a beat accepted at edge t is visible on `out_*` after edge t.
- Throughput is 1 beat per cycle while `out_ready` is high.
- When `out_ready` is low, the block absorbs at most 2 beats, then `in_ready` drops on the following cycle.
- Simultaneous accept and transfer with main full and skid empty: the new beat loads main directly; skid stays empty.
- Simultaneous accept and transfer with skid full cannot happen, because `in_ready` is low.
- Reset values: `out_valid`=0, `in_ready`=1, `out_data`=0, `out_sel`=0, `sel_err`=0, skid valid=0.
- Reset asserted mid-stream discards all held beats on the next edge. `rst` has priority over `flush` and over accept.

## Configuration
- `MUXN_SKID_EN` defined: the 2-entry structure described above. `in_ready` is registered.
- `MUXN_SKID_EN` undefined: no skid register; main register only.
  - `in_ready = (!out_valid || out_ready) && !flush`, which is combinational from `out_ready`.
  - Throughput is still 1 per cycle; capacity is 1 beat.
  - All other behaviour (`sel_err`, `flush`, reset values, latency) is identical.

## Test plan
All scenarios use `N`=3, `WIDTH`=8, inputs d0=0x11, d1=0x22, d2=0x33.
- Streaming: `out_ready`=1, `in_sel` sequence 0,1,2,1 on consecutive cycles → `out_data` 0x11,0x22,0x33,0x22 one cycle later each; `in_ready` stays 1.
- Back-pressure (skid): `out_ready`=0, offer selects 2 then 0 → both accepted, `in_ready`=0 from the third cycle. Raise `out_ready` → 0x33 then 0x11, no loss, no duplication.
- Out of range: `in_sel`=3 accepted → `out_data`=0x00, `out_sel`=3, `sel_err`=1. `sel_err` stays 1 through later valid beats and through `flush`; clears only on `rst`.
- Flush with 2 held beats and `in_valid`=1 (select 1) → `in_ready`=0 that cycle, `out_valid`=0 next cycle, and no 0x22 beat ever emerges.
- Reset mid-stream with skid full → next cycle `out_valid`=0, `in_ready`=1, `out_data`=0x00, `sel_err`=0.
- Build without `MUXN_SKID_EN`: `out_ready`=0 with one beat held → `in_ready`=0. Toggling `out_ready` to 1 raises `in_ready` in the same cycle, and a beat with select 2 gives 0x33 at 1-cycle latency.
